// File: rtl/dense1_pkg.sv
// Shared constants and FSM state type for the Dense_1 result packer.
// The packer top and its nibble sub-module both import this package.
package dense1_pkg;

  localparam int NUM_ELEMS      = 128;
  localparam int ELEM_W         = 4;
  localparam int WORD_W         = 32;
  localparam int RELU6_MAX      = 6;
  localparam int ELEMS_PER_WORD = WORD_W / ELEM_W;
  localparam int NUM_WORDS      = NUM_ELEMS / ELEMS_PER_WORD;
  localparam int LANE_W         = $clog2(ELEMS_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_WAIT_UP,
    ST_GATHER,
    ST_EMIT,
    ST_FIN
  } packer_state_t;

endpackage

// File: rtl/nibble_word_packer.sv
// Assembles ELEMS_PER_WORD activations into one word, one lane per load.
// word_o already includes the lane being loaded this cycle.
module nibble_word_packer
  import dense1_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [ELEM_W-1:0] data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  always_comb begin
    // NOTE: word_d takes word_q first so every path assigns it and no latch is inferred.
    word_d = word_q;
    if (clear_i) begin
      word_d = '0;
    end else if (load_i) begin
      for (int l = 0; l < ELEMS_PER_WORD; l++) begin
        if (lane_i == LANE_W'(l)) begin
          word_d[l*ELEM_W +: ELEM_W] = data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  // Look-ahead output lets the caller capture a complete word on the lane-7 load.
  assign word_o = word_d;
  assign full_o = load_i && (lane_i == LANE_W'(ELEMS_PER_WORD - 1));

endmodule

// File: rtl/dense1_result_packer.sv
// Dense_1 result packer: triggers the dense stage, sweeps its activations and
// streams them as packed words over a valid/ready interface.
module dense1_result_packer
  import dense1_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic              up_start,
  input  logic              up_done,
  output logic [ADDR_W-1:0] up_read_addr,
  input  logic [ELEM_W-1:0] up_read_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last
);

  localparam int WCNT_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ELEMS - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

  packer_state_t     state_q;
  logic              busy_q;
  logic              done_q;
  logic              range_err_q;
  logic              up_start_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WCNT_W-1:0] word_cnt_q;
  logic [WORD_W-1:0] m_data_q;

  logic              pk_clear;
  logic              pk_load;
  logic              pk_full;
  logic [WORD_W-1:0] pk_word;
  logic              elem_over;

  assign pk_clear  = (state_q == ST_IDLE) && start;
  assign pk_load   = (state_q == ST_GATHER);
  assign elem_over = up_read_data > ELEM_W'(RELU6_MAX);

  nibble_word_packer u_packer (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (pk_clear),
    .load_i  (pk_load),
    .lane_i  (addr_q[LANE_W-1:0]),
    .data_i  (up_read_data),
    .word_o  (pk_word),
    .full_o  (pk_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      up_start_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      m_data_q    <= '0;
    end else begin
      // NOTE: non-blocking throughout; pulse outputs default low and are raised only by their state.
      up_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_KICK;
            busy_q      <= 1'b1;
            up_start_q  <= 1'b1;
            range_err_q <= 1'b0;
            addr_q      <= '0;
            word_cnt_q  <= '0;
          end
        end
        ST_KICK: begin
          state_q <= ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (up_done) begin
            addr_q  <= '0;
            state_q <= ST_GATHER;
          end
        end
        ST_GATHER: begin
          // Out-of-range samples are flagged but still packed unmodified.
          if (elem_over) begin
            range_err_q <= 1'b1;
          end
          if (addr_q != LAST_ADDR) begin
            addr_q <= addr_q + ADDR_W'(1);
          end
          if (pk_full) begin
            m_data_q  <= pk_word;
            m_valid_q <= 1'b1;
            m_last_q  <= (word_cnt_q == LAST_WORD);
            state_q   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (m_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              word_cnt_q <= word_cnt_q + WCNT_W'(1);
              state_q    <= ST_GATHER;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign range_err    = range_err_q;
  assign up_start     = up_start_q;
  assign up_read_addr = addr_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;

endmodule

// File: tb/tb_dense1_result_packer.sv
// Self-checking bench for dense1_result_packer: a table of frame scenarios run
// against an array-based model of the upstream stage, plus reset and spurious-event sequences.
module tb_dense1_result_packer;
  import dense1_pkg::*;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        busy;
  logic        done;
  logic        range_err;
  logic        up_start;
  logic        up_done;
  logic [6:0]  up_read_addr;
  logic [3:0]  up_read_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  logic [3:0] act_mem [NUM_ELEMS];
  assign up_read_data = act_mem[up_read_addr];

  dense1_result_packer #(.ADDR_W(7)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .range_err    (range_err),
    .up_start     (up_start),
    .up_done      (up_done),
    .up_read_addr (up_read_addr),
    .up_read_data (up_read_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_word(input int w);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc | (32'(act_mem[8*w+i]) << (4*i));
    return acc;
  endfunction

  function automatic logic model_any_over();
    for (int k = 0; k < NUM_ELEMS; k++) if (act_mem[k] > 4'd6) return 1'b1;
    return 1'b0;
  endfunction

  task automatic fill_pattern(input int pat, input int fidx, input logic [3:0] fval);
    for (int k = 0; k < NUM_ELEMS; k++) begin
      case (pat)
        0:       act_mem[k] = 4'(k % 7);
        1:       act_mem[k] = 4'($urandom_range(0, 6));
        default: act_mem[k] = 4'($urandom_range(0, 15));
      endcase
    end
    if (fidx >= 0) act_mem[fidx] = fval;
  endtask

  // ---------------- frame results ----------------
  logic [31:0] words [$];
  logic        lasts [$];
  int   upstart_cnt, gather_cyc, stable_bad, addr_bad, err_track_bad, done_lat, rst_bad;
  bit   timeout, aborted;
  logic err_after_start, busy_after_start, fin_busy, fin_err, post_fin_busy, post_fin_upstart;

  task automatic run_frame(input int ready_mode, input int delay, input bit poke, input int abort_word);
    int   n;
    bit   holding, poked_emit;
    logic exp_err_run;
    logic ready_v;
    logic [31:0] held;
    words.delete();
    lasts.delete();
    upstart_cnt = 0; gather_cyc = 0; stable_bad = 0; addr_bad = 0; err_track_bad = 0;
    done_lat = -1; rst_bad = 0; timeout = 0; aborted = 0;
    holding = 0; poked_emit = 0; exp_err_run = 1'b0; held = '0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (up_start) upstart_cnt++;
    err_after_start  = range_err;
    busy_after_start = busy;
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (up_start) upstart_cnt++;
    end
    up_done = 1'b1;
    @(negedge clk);
    up_done = 1'b0;

    n = 1;
    while (n < 3000) begin
      if (up_start) upstart_cnt++;
      if (done) begin
        done_lat = n;
        break;
      end
      if (busy && range_err !== exp_err_run) err_track_bad++;
      if (busy && !m_valid) begin
        if (up_read_addr != 7'(gather_cyc)) addr_bad++;
        if (act_mem[up_read_addr] > 4'd6) exp_err_run = 1'b1;
        gather_cyc++;
      end
      case (ready_mode)
        0:       ready_v = 1'b1;
        1:       ready_v = ((n % 2) == 1);
        default: ready_v = 1'($urandom_range(0, 1));
      endcase
      if (m_valid) begin
        if (holding && m_data !== held) stable_bad++;
        if (abort_word >= 0 && words.size() == abort_word) begin
          m_ready = 1'b0;
          resetn  = 1'b0;
          #1;
          rst_bad = int'(busy) + int'(done) + int'(range_err) + int'(up_start) + int'(m_valid)
                  + int'(m_last) + int'(up_read_addr != 0) + int'(m_data != 0);
          aborted = 1;
          @(negedge clk);
          resetn = 1'b1;
          break;
        end
        if (ready_v) begin
          words.push_back(m_data);
          lasts.push_back(m_last);
          holding = 0;
        end else begin
          holding = 1;
          held    = m_data;
          if (poke && !poked_emit) begin
            start      = 1'b1;
            poked_emit = 1;
          end
        end
      end else begin
        holding = 0;
      end
      m_ready = ready_v;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    m_ready = 1'b0;

    if (!aborted) begin
      if (done_lat < 0) begin
        timeout = 1;
      end else begin
        fin_busy = busy;
        fin_err  = range_err;
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        post_fin_busy    = busy;
        post_fin_upstart = up_start;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int exp_lat, input bit w0_const,
                             input logic [31:0] exp_w0, input logic exp_err);
    int wbad;
    int lastbad;
    wbad = 0;
    lastbad = 0;
    check({tag, ":timeout"}, 64'(timeout), 0);
    check({tag, ":busy_after_start"}, 64'(busy_after_start), 1);
    check({tag, ":err_cleared_on_start"}, 64'(err_after_start), 0);
    check({tag, ":up_start_pulses"}, 64'(upstart_cnt), 1);
    check({tag, ":word_count"}, 64'(words.size()), 16);
    for (int w = 0; w < words.size(); w++) begin
      if (words[w] !== model_word(w)) wbad++;
      if (lasts[w] !== 1'(w == 15)) lastbad++;
    end
    check({tag, ":word_mismatches"}, 64'(wbad), 0);
    check({tag, ":m_last_misplaced"}, 64'(lastbad), 0);
    if (w0_const && words.size() > 0) check({tag, ":word0"}, 64'(words[0]), 64'(exp_w0));
    check({tag, ":gather_cycles"}, 64'(gather_cyc), 128);
    check({tag, ":read_addr_sequence"}, 64'(addr_bad), 0);
    check({tag, ":m_data_stable_stall"}, 64'(stable_bad), 0);
    check({tag, ":range_err_tracking"}, 64'(err_track_bad), 0);
    check({tag, ":range_err_at_done"}, 64'(fin_err), 64'(exp_err));
    check({tag, ":busy_low_in_fin"}, 64'(fin_busy), 0);
    check({tag, ":idle_after_fin"}, 64'(post_fin_busy), 0);
    check({tag, ":no_kick_after_fin"}, 64'(post_fin_upstart), 0);
    if (exp_lat > 0) check({tag, ":done_latency"}, 64'(done_lat), 64'(exp_lat));
  endtask

  typedef struct {
    int          pattern;
    int          ready_mode;
    int          force_idx;
    logic [3:0]  force_val;
    int          delay;
    bit          poke;
    bit          w0_const;
    logic [31:0] exp_w0;
    bit          err_model;
    logic        exp_err;
    int          exp_lat;
  } frame_vec_t;

  frame_vec_t vecs [6];
  int         spurious_act;

  initial begin
    total = 0; bad = 0;
    resetn = 1'b1; start = 1'b0; up_done = 1'b0; m_ready = 1'b0;
    for (int k = 0; k < NUM_ELEMS; k++) act_mem[k] = '0;

    vecs[0] = '{0, 0, -1, 4'h0, 3, 1'b0, 1'b1, 32'h0654_3210, 1'b0, 1'b0, 145};
    vecs[1] = '{0, 1, -1, 4'h0, 3, 1'b1, 1'b1, 32'h0654_3210, 1'b0, 1'b0, 0};
    vecs[2] = '{0, 0, 77, 4'hF, 2, 1'b0, 1'b1, 32'h0654_3210, 1'b0, 1'b1, 145};
    vecs[3] = '{0, 0, -1, 4'h0, 5, 1'b0, 1'b1, 32'h0654_3210, 1'b0, 1'b0, 145};
    vecs[4] = '{1, 2, -1, 4'h0, 4, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 0};
    vecs[5] = '{2, 2, -1, 4'h0, 2, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 0};

    #2 resetn = 1'b0;
    #1;
    check("reset_outputs",
          64'({busy, done, range_err, up_start, up_read_addr, m_valid, m_data, m_last}), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      fill_pattern(vecs[v].pattern, vecs[v].force_idx, vecs[v].force_val);
      run_frame(vecs[v].ready_mode, vecs[v].delay, vecs[v].poke, -1);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_lat, vecs[v].w0_const, vecs[v].exp_w0,
                  vecs[v].err_model ? model_any_over() : vecs[v].exp_err);
      if (vecs[v].force_idx == 77)
        check("vec2:word9_nibble5", 64'(words.size() > 9 ? words[9][23:20] : 4'h0), 64'hF);
      repeat (2) @(negedge clk);
    end

    // Spurious up_done while idle must not start anything.
    up_done = 1'b1;
    @(negedge clk);
    up_done = 1'b0;
    spurious_act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || up_start || m_valid || done) spurious_act++;
    end
    check("spurious_up_done_idle", 64'(spurious_act), 0);

    // Reset while word 6 sits in EMIT, then a late up_done, then a fresh frame.
    fill_pattern(0, -1, 4'h0);
    run_frame(0, 2, 1'b0, 6);
    check("abort:reset_hit", 64'(aborted), 1);
    check("abort:outputs_zero_async", 64'(rst_bad), 0);
    up_done = 1'b1;
    @(negedge clk);
    up_done = 1'b0;
    spurious_act = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || up_start || m_valid || done) spurious_act++;
    end
    check("abort:late_up_done_ignored", 64'(spurious_act), 0);
    run_frame(0, 3, 1'b0, -1);
    check_frame("after_reset", 145, 1'b1, 32'h0654_3210, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
